note_stabilizer: RTL and testbench

//  Sits between note_lookup and note_write in the transcription pipeline.

---
 rtl/note_stab_pkg.sv | 26 ++
 rtl/note_stabilizer_if.sv | 32 +++
 rtl/note_stabilizer_fifo.sv | 77 +++++++
 rtl/note_stabilizer.sv | 154 +++++++++++++++
 tb/tb_note_stabilizer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/note_stab_pkg.sv
`default_nettype none
// ============================================================================
// note_stab_pkg : shared event types and helpers for the note stabilizer
// Rev 1.0
// ============================================================================
package note_stab_pkg;

   localparam logic [5:0] NOTE_NONE = 6'd63;

   typedef enum logic {
      EVT_ONSET   = 1'b0,
      EVT_RELEASE = 1'b1
   } evt_kind_t;

   typedef struct packed {
      evt_kind_t  kind;
      logic [5:0] note;
      logic [7:0] dur;
   } note_evt_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/note_stabilizer_if.sv
`default_nettype none
// ============================================================================
// note_stabilizer_if : frame input and note-event output bundle
// Rev 1.0
// ============================================================================
interface note_stabilizer_if #(
   parameter int MAG_W = 16
);
   logic [5:0]       note_in;
   logic [MAG_W-1:0] mag_in;
   logic             frame_valid_in;
   logic             evt_ready_in;
   logic             evt_valid_out;
   logic             evt_kind_out;
   logic [5:0]       evt_note_out;
   logic [7:0]       evt_dur_out;
   logic [5:0]       cur_note_out;
   logic             overflow_out;

   modport master (
      output note_in, mag_in, frame_valid_in, evt_ready_in,
      input  evt_valid_out, evt_kind_out, evt_note_out, evt_dur_out,
             cur_note_out, overflow_out
   );

   modport slave (
      input  note_in, mag_in, frame_valid_in, evt_ready_in,
      output evt_valid_out, evt_kind_out, evt_note_out, evt_dur_out,
             cur_note_out, overflow_out
   );
endinterface
`default_nettype wire

// File: rtl/note_stabilizer_fifo.sv
`default_nettype none
// ============================================================================
// note_event_fifo : synchronous FIFO of note events with registered head
// Rev 1.0
// ============================================================================
module note_event_fifo
   import note_stab_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic      clk_in,
   input  wire logic      rst_in,
   input  wire logic      push_in,
   input  var  note_evt_t push_data_in,
   input  wire logic      ready_in,
   output logic           valid_out,
   output note_evt_t      data_out,
   output logic           overflow_out
);
   localparam int AW = $clog2(FIFO_DEPTH);

   note_evt_t      r_mem [FIFO_DEPTH];
   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;
   logic           r_valid;
   note_evt_t      r_data;
   logic           r_overflow;

   logic           w_full;
   logic           w_pop;
   logic           w_do_push;
   logic [AW:0]    w_wr_ptr_n;
   logic [AW:0]    w_rd_ptr_n;

   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop      = r_valid && ready_in;
   assign w_do_push  = push_in && (!w_full || w_pop);
   assign w_wr_ptr_n = r_wr_ptr + {{AW{1'b0}}, w_do_push};
   assign w_rd_ptr_n = r_rd_ptr + {{AW{1'b0}}, w_pop};

   always_ff @(posedge clk_in) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= push_data_in;
      end
   end

   // Head register is loaded from next-state pointers; a push into the slot
   // that becomes the head is forwarded since the array write lands this edge.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_n;
         r_rd_ptr <= w_rd_ptr_n;
         r_valid  <= (w_wr_ptr_n != w_rd_ptr_n);
         if (w_do_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_n[AW-1:0])) begin
            r_data <= push_data_in;
         end else begin
            r_data <= r_mem[w_rd_ptr_n[AW-1:0]];
         end
         if (push_in && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign valid_out    = r_valid;
   assign data_out     = r_data;
   assign overflow_out = r_overflow;

endmodule
`default_nettype wire

// File: rtl/note_stabilizer.sv
`default_nettype none
// ============================================================================
// note_stabilizer : debounces per-frame pitch decisions into ONSET/RELEASE events
// Rev 1.0
// ============================================================================
module note_stabilizer
   import note_stab_pkg::*;
#(
   parameter int MAG_W          = 16,
   parameter int MAG_THRESH     = 256,
   parameter int STABLE_FRAMES  = 3,
   parameter int RELEASE_FRAMES = 2,
   parameter int FIFO_DEPTH     = 4
) (
   input wire logic          clk_in,
   input wire logic          rst_in,
   note_stabilizer_if.slave  bus
);
   localparam int CW = $clog2(STABLE_FRAMES + 2);
   localparam int MW = $clog2(RELEASE_FRAMES + 1);

   localparam logic [MAG_W-1:0] c_mag_thresh = MAG_W'(MAG_THRESH);
   localparam logic [CW-1:0]    c_stable     = CW'(STABLE_FRAMES);
   localparam logic [CW-1:0]    c_cnt_one    = CW'(1);
   localparam logic [MW-1:0]    c_release    = MW'(RELEASE_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CAND = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t         r_state;
   logic [5:0]     r_cand_note;
   logic [CW-1:0]  r_cand_cnt;
   logic [5:0]     r_hold_note;
   logic [7:0]     r_dur;
   logic [MW-1:0]  r_miss_cnt;
   logic [5:0]     r_cur_note;
   logic           r_push;
   note_evt_t      r_push_evt;

   logic           w_hit;
   logic [5:0]     w_cand_nxt_note;
   logic [CW-1:0]  w_cand_nxt_cnt;
   logic           w_commit;
   logic [MW-1:0]  w_miss_inc;
   logic [7:0]     w_dur_inc;
   note_evt_t      w_head;
   logic           w_fifo_valid;
   logic           w_overflow;

   assign w_hit = bus.frame_valid_in && (bus.note_in != NOTE_NONE) &&
                  (bus.mag_in >= c_mag_thresh);

   // Candidate tracking shared by IDLE and CAND: continue a matching run or start afresh.
   always_comb begin
      w_cand_nxt_note = bus.note_in;
      w_cand_nxt_cnt  = c_cnt_one;
      if ((r_state == S_CAND) && (bus.note_in == r_cand_note)) begin
         w_cand_nxt_note = r_cand_note;
         w_cand_nxt_cnt  = r_cand_cnt + c_cnt_one;
      end
   end

   assign w_commit   = (w_cand_nxt_cnt >= c_stable);
   assign w_miss_inc = r_miss_cnt + MW'(1);
   assign w_dur_inc  = sat_inc8(r_dur);

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state     <= S_IDLE;
         r_cand_note <= '0;
         r_cand_cnt  <= '0;
         r_hold_note <= NOTE_NONE;
         r_dur       <= '0;
         r_miss_cnt  <= '0;
         r_cur_note  <= NOTE_NONE;
         r_push      <= 1'b0;
         r_push_evt  <= '0;
      end else begin
         r_push <= 1'b0;
         if (bus.frame_valid_in) begin
            unique case (r_state)
               S_IDLE, S_CAND: begin
                  if (!w_hit) begin
                     r_state    <= S_IDLE;
                     r_cand_cnt <= '0;
                  end else if (w_commit) begin
                     r_state     <= S_HOLD;
                     r_hold_note <= w_cand_nxt_note;
                     r_cur_note  <= w_cand_nxt_note;
                     r_dur       <= '0;
                     r_miss_cnt  <= '0;
                     r_cand_cnt  <= '0;
                     r_push      <= 1'b1;
                     r_push_evt  <= '{kind: EVT_ONSET, note: w_cand_nxt_note, dur: 8'd0};
                  end else begin
                     r_state     <= S_CAND;
                     r_cand_note <= w_cand_nxt_note;
                     r_cand_cnt  <= w_cand_nxt_cnt;
                  end
               end
               S_HOLD: begin
                  r_dur <= w_dur_inc;
                  if (w_hit && (bus.note_in == r_hold_note)) begin
                     r_miss_cnt <= '0;
                  end else if (w_miss_inc == c_release) begin
                     // A hit on another note seeds the next candidate; it never commits
                     // here so that at most one event is pushed per frame.
                     r_miss_cnt <= '0;
                     r_cur_note <= NOTE_NONE;
                     r_push     <= 1'b1;
                     r_push_evt <= '{kind: EVT_RELEASE, note: r_hold_note, dur: w_dur_inc};
                     if (w_hit) begin
                        r_state     <= S_CAND;
                        r_cand_note <= bus.note_in;
                        r_cand_cnt  <= c_cnt_one;
                     end else begin
                        r_state     <= S_IDLE;
                        r_cand_cnt  <= '0;
                     end
                  end else begin
                     r_miss_cnt <= w_miss_inc;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   note_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (r_push),
      .push_data_in (r_push_evt),
      .ready_in     (bus.evt_ready_in),
      .valid_out    (w_fifo_valid),
      .data_out     (w_head),
      .overflow_out (w_overflow)
   );

   assign bus.evt_valid_out = w_fifo_valid;
   assign bus.evt_kind_out  = w_head.kind;
   assign bus.evt_note_out  = w_head.note;
   assign bus.evt_dur_out   = w_head.dur;
   assign bus.cur_note_out  = r_cur_note;
   assign bus.overflow_out  = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_note_stabilizer.sv
`default_nettype none
// ============================================================================
// tb_note_stabilizer : directed self-checking bench for note_stabilizer
// Rev 1.0
// ============================================================================
module tb_note_stabilizer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   n_fail;

   note_stabilizer_if #(.MAG_W(16)) bus ();

   note_stabilizer #(
      .MAG_W          (16),
      .MAG_THRESH     (256),
      .STABLE_FRAMES  (3),
      .RELEASE_FRAMES (2),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [5:0] n, input logic [15:0] m);
      @(negedge clk);
      bus.note_in        = n;
      bus.mag_in         = m;
      bus.frame_valid_in = 1'b1;
      @(negedge clk);
      bus.frame_valid_in = 1'b0;
   endtask

   task automatic frames(input logic [5:0] n, input logic [15:0] m, input int cnt);
      for (int i = 0; i < cnt; i++) frame(n, m);
   endtask

   // Waits (bounded) for an event, checks it, then pops it with a one-cycle ready pulse.
   task automatic expect_evt(input string tag, input logic kind, input logic [5:0] note,
                             input logic [7:0] dur);
      for (int i = 0; i < 20; i++) begin
         if (bus.evt_valid_out === 1'b1) break;
         @(negedge clk);
      end
      check({tag, "_valid"}, bus.evt_valid_out, 1);
      check({tag, "_kind"},  bus.evt_kind_out,  kind);
      check({tag, "_note"},  bus.evt_note_out,  note);
      check({tag, "_dur"},   bus.evt_dur_out,   dur);
      bus.evt_ready_in = 1'b1;
      @(negedge clk);
      bus.evt_ready_in = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      rst_n              = 1'b0;
      bus.note_in        = 6'd0;
      bus.mag_in         = 16'd0;
      bus.frame_valid_in = 1'b0;
      bus.evt_ready_in   = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_valid", bus.evt_valid_out, 0);
      check("rst_kind",  bus.evt_kind_out,  0);
      check("rst_note",  bus.evt_note_out,  0);
      check("rst_dur",   bus.evt_dur_out,   0);
      check("rst_cur",   bus.cur_note_out,  63);
      check("rst_ovf",   bus.overflow_out,  0);
      rst_n = 1'b1;

      // Onset latency with ready held high
      bus.evt_ready_in = 1'b1;
      frames(6'd20, 16'd1000, 3);
      check("t1_cur",    bus.cur_note_out,  20);
      check("t1_lat1",   bus.evt_valid_out, 0);
      @(negedge clk);
      check("t1_lat2",   bus.evt_valid_out, 1);
      check("t1_kind",   bus.evt_kind_out,  0);
      check("t1_note",   bus.evt_note_out,  20);
      check("t1_dur",    bus.evt_dur_out,   0);
      @(negedge clk);
      check("t1_popped", bus.evt_valid_out, 0);
      bus.evt_ready_in = 1'b0;

      // Quiet frames release the held note
      frames(6'd20, 16'd1000, 4);
      frames(6'd20, 16'd100, 2);
      check("t3_cur", bus.cur_note_out, 63);
      expect_evt("t3_rel", 1'b1, 6'd20, 8'd6);

      // Candidate restarts on a note change
      frames(6'd20, 16'd1000, 2);
      frames(6'd21, 16'd1000, 2);
      @(negedge clk);
      check("t2_none", bus.evt_valid_out, 0);
      check("t2_cur0", bus.cur_note_out,  63);
      frame(6'd21, 16'd1000);
      expect_evt("t2_on", 1'b0, 6'd21, 8'd0);
      check("t2_single", bus.evt_valid_out, 0);
      check("t2_cur",    bus.cur_note_out,  21);
      frame(6'd63, 16'd1000);
      frame(6'd21, 16'd10);
      expect_evt("t2_rel", 1'b1, 6'd21, 8'd2);

      // A single miss is forgiven when the note returns
      frames(6'd20, 16'd1000, 3);
      expect_evt("t4_on", 1'b0, 6'd20, 8'd0);
      frames(6'd20, 16'd1000, 2);
      frame(6'd20, 16'd100);
      frame(6'd20, 16'd1000);
      frame(6'd20, 16'd100);
      @(negedge clk);
      check("t4_norel", bus.evt_valid_out, 0);
      check("t4_cur",   bus.cur_note_out,  20);
      frame(6'd20, 16'd100);
      expect_evt("t4_rel", 1'b1, 6'd20, 8'd6);

      // Frames without strobe are ignored; release straight into a new candidate
      frames(6'd33, 16'd1000, 2);
      bus.note_in = 6'd40;
      bus.mag_in  = 16'd5000;
      repeat (5) @(negedge clk);
      check("tg_idle", bus.evt_valid_out, 0);
      frame(6'd33, 16'd1000);
      expect_evt("tg_on33", 1'b0, 6'd33, 8'd0);
      frames(6'd34, 16'd1000, 4);
      expect_evt("tg_rel33", 1'b1, 6'd33, 8'd2);
      expect_evt("tg_on34",  1'b0, 6'd34, 8'd0);
      frames(6'd0, 16'd0, 2);
      expect_evt("tg_rel34", 1'b1, 6'd34, 8'd2);

      // Overflow: five events against a four-deep buffer
      frames(6'd40, 16'd1000, 3);
      frames(6'd40, 16'd0, 2);
      frames(6'd41, 16'd1000, 3);
      frames(6'd41, 16'd0, 2);
      repeat (2) @(negedge clk);
      check("t5_ovf0", bus.overflow_out, 0);
      frames(6'd42, 16'd1000, 3);
      repeat (2) @(negedge clk);
      check("t5_ovf1", bus.overflow_out, 1);
      check("t5_cur",  bus.cur_note_out, 42);
      expect_evt("t5_e0", 1'b0, 6'd40, 8'd0);
      expect_evt("t5_e1", 1'b1, 6'd40, 8'd2);
      expect_evt("t5_e2", 1'b0, 6'd41, 8'd0);
      expect_evt("t5_e3", 1'b1, 6'd41, 8'd2);
      check("t5_empty",  bus.evt_valid_out, 0);
      check("t5_sticky", bus.overflow_out,  1);
      frames(6'd42, 16'd0, 2);
      expect_evt("t5_rel42", 1'b1, 6'd42, 8'd2);

      // Duration saturation, then reset while holding with an event queued
      frames(6'd20, 16'd1000, 3);
      expect_evt("t6_on", 1'b0, 6'd20, 8'd0);
      frames(6'd20, 16'd1000, 300);
      frames(6'd20, 16'd0, 2);
      expect_evt("t6_sat", 1'b1, 6'd20, 8'd255);
      frames(6'd20, 16'd1000, 5);
      check("t6_pend", bus.evt_valid_out, 1);
      check("t6_hold", bus.cur_note_out,  20);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_valid", bus.evt_valid_out, 0);
      check("t6_rst_kind",  bus.evt_kind_out,  0);
      check("t6_rst_note",  bus.evt_note_out,  0);
      check("t6_rst_dur",   bus.evt_dur_out,   0);
      check("t6_rst_cur",   bus.cur_note_out,  63);
      check("t6_rst_ovf",   bus.overflow_out,  0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_norel", bus.evt_valid_out, 0);
      check("t6_cur",   bus.cur_note_out,  63);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
